// File: rtl/logic_analyzer_capture_encoder.sv
// Logic-analyzer front end: timestamps changes on 4 synchronized probe lines and streams 6-byte records.
// States: IDLE stopped | WAIT_TRIG waiting for trigger pattern (LA_CAPTURE_TRIGGER_EN only) | CAPTURE timestamping.
module logic_analyzer_capture_encoder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       arm,
  input  logic [3:0] sig,
  input  logic       fifo_full,
`ifdef LA_CAPTURE_TRIGGER_EN
  input  logic [3:0] trig_mask,
  input  logic [3:0] trig_value,
`endif
  output logic       data_strobe,
  output logic [7:0] data,
  output logic       overflow,
  output logic       capturing
);

`ifdef LA_CAPTURE_TRIGGER_EN
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_CAPTURE   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd2
  } state_t;
`endif

  state_t      r_state;
  logic        r_capturing;
  logic        r_arm_d;
  logic [43:0] r_ts;
  logic [3:0]  r_sync [SYNC_STAGES];
  logic [3:0]  r_prev;

  logic        r_busy;
  logic [2:0]  r_idx;
  logic [47:0] r_rec;
  logic        r_pend_vld;
  logic [47:0] r_pend;
  logic        r_overflow;

  logic [3:0]  w_s_sync;
  logic        w_arm_rise;
  logic        w_rec_vld;
  logic [47:0] w_rec;
  logic        w_last;
  logic [7:0]  w_byte;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 4'h0;
      r_prev <= 4'h0;
    end else begin
      r_sync[0] <= sig;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_s_sync   = r_sync[SYNC_STAGES-1];
  assign w_arm_rise = arm & ~r_arm_d;
  // ts is 0 both on entry and right after a wrap, so one term covers the initial record and the keepalive.
  assign w_rec_vld  = (r_state == ST_CAPTURE) & ((w_s_sync != r_prev) | (r_ts == 44'd0));
  assign w_rec      = {w_s_sync, r_ts};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_capturing <= 1'b0;
      r_arm_d     <= 1'b0;
      r_ts        <= 44'd0;
    end else begin
      r_arm_d <= arm;
      if (!arm) begin
        r_state     <= ST_IDLE;
        r_capturing <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (!r_arm_d) begin
`ifdef LA_CAPTURE_TRIGGER_EN
              r_state     <= ST_WAIT_TRIG;
`else
              r_state     <= ST_CAPTURE;
              r_capturing <= 1'b1;
              r_ts        <= 44'd0;
`endif
            end
          end
`ifdef LA_CAPTURE_TRIGGER_EN
          ST_WAIT_TRIG: begin
            if ((w_s_sync & trig_mask) == (trig_value & trig_mask)) begin
              r_state     <= ST_CAPTURE;
              r_capturing <= 1'b1;
              r_ts        <= 44'd0;
            end
          end
`endif
          ST_CAPTURE: r_ts <= r_ts + 44'd1;
          default: begin
            r_state     <= ST_IDLE;
            r_capturing <= 1'b0;
          end
        endcase
      end
    end
  end

  assign w_last = r_busy & ~fifo_full & (r_idx == 3'd5);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy     <= 1'b0;
      r_idx      <= 3'd0;
      r_rec      <= 48'd0;
      r_pend_vld <= 1'b0;
      r_pend     <= 48'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_arm_rise)
        r_overflow <= 1'b0;
      else if (w_rec_vld && r_busy && r_pend_vld)
        r_overflow <= 1'b1;

      if (!r_busy) begin
        if (w_rec_vld) begin
          r_busy <= 1'b1;
          r_idx  <= 3'd0;
          r_rec  <= w_rec;
        end
      end else if (!fifo_full) begin
        if (r_idx == 3'd5) begin
          r_idx <= 3'd0;
          if (r_pend_vld) begin
            r_rec      <= r_pend;
            r_pend_vld <= 1'b0;
          end else if (w_rec_vld) begin
            // record lands as the serializer drains: go straight in, no gap
            r_rec <= w_rec;
          end else begin
            r_busy <= 1'b0;
          end
        end else begin
          r_idx <= r_idx + 3'd1;
        end
      end

      if (r_busy && w_rec_vld && !r_pend_vld && !w_last) begin
        r_pend     <= w_rec;
        r_pend_vld <= 1'b1;
      end
    end
  end

  always_comb begin
    w_byte = 8'h00;
    unique case (r_idx)
      3'd0:    w_byte = r_rec[47:40];
      3'd1:    w_byte = r_rec[39:32];
      3'd2:    w_byte = r_rec[31:24];
      3'd3:    w_byte = r_rec[23:16];
      3'd4:    w_byte = r_rec[15:8];
      3'd5:    w_byte = r_rec[7:0];
      default: w_byte = 8'h00;
    endcase
  end

  assign data_strobe = r_busy & ~fifo_full;
  assign data        = r_busy ? w_byte : 8'h00;
  assign overflow    = r_overflow;
  assign capturing   = r_capturing;

endmodule

// File: tb/tb_logic_analyzer_capture_encoder.sv
// Bench for logic_analyzer_capture_encoder: directed scenarios plus random traffic against a byte-queue reference model.
module tb_logic_analyzer_capture_encoder;
  localparam int SYNC = 2;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       arm;
  logic [3:0] sig;
  logic       fifo_full;
  logic       data_strobe;
  logic [7:0] data;
  logic       overflow;
  logic       capturing;

  logic_analyzer_capture_encoder #(.SYNC_STAGES(SYNC)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .arm         (arm),
    .sig         (sig),
    .fifo_full   (fifo_full),
    .data_strobe (data_strobe),
    .data        (data),
    .overflow    (overflow),
    .capturing   (capturing)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: probe history, capture flag, timestamp and the byte stream still owed downstream.
  logic [3:0]  m_hist[$];
  bit          m_cap;
  bit          m_arm_d;
  logic [43:0] m_ts;
  bit          m_ovf;
  logic [7:0]  m_q[$];
  logic [7:0]  obs[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i <= SYNC; i++) m_hist.push_back(4'h0);
    m_cap   = 0;
    m_arm_d = 0;
    m_ts    = '0;
    m_ovf   = 0;
    m_q.delete();
  endtask

  task automatic model_tick();
    logic [3:0]  s_now;
    logic [3:0]  s_old;
    logic [47:0] rec;
    int          held;
    s_now = m_hist[SYNC-1];
    s_old = m_hist[SYNC];
    held  = (m_q.size() + 5) / 6;
    if (m_q.size() > 0 && !fifo_full) void'(m_q.pop_front());
    if (m_cap && (s_now != s_old || m_ts == 44'd0)) begin
      if (held < 2) begin
        rec = {s_now, m_ts};
        for (int i = 5; i >= 0; i--) m_q.push_back(rec[i*8 +: 8]);
      end else begin
        m_ovf = 1;
      end
    end
    if (!arm) m_cap = 0;
    else if (!m_arm_d) begin
      m_cap = 1;
      m_ts  = '0;
      m_ovf = 0;
    end else if (m_cap) m_ts = m_ts + 44'd1;
    m_arm_d = arm;
    m_hist.push_front(sig);
    void'(m_hist.pop_back());
  endtask

  // Called just after a negedge with inputs set: sample/compare, then advance one clock.
  task automatic step();
    bit exp_stb;
    #1;
    exp_stb = (m_q.size() > 0) && !fifo_full;
    check_val("strobe", data_strobe, exp_stb);
    if (exp_stb) check_val("data", data, m_q[0]);
    check_val("overflow", overflow, m_ovf);
    check_val("capturing", capturing, m_cap);
    if (data_strobe) obs.push_back(data);
    @(posedge clock);
    model_tick();
    @(negedge clock);
  endtask

  task automatic run_until_bytes(input int n, input int budget);
    int k = 0;
    while (obs.size() < n && k < budget) begin
      step();
      k++;
    end
    check_val("bytes_seen", obs.size() >= n, 1);
  endtask

  task automatic check_bytes(input string tag, input int base, input logic [47:0] exp);
    for (int i = 0; i < 6; i++) check_val(tag, obs[base+i], exp[(5-i)*8 +: 8]);
  endtask

  initial begin
    int k;
    reset_n = 0; arm = 0; sig = 4'h0; fifo_full = 0;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_val("rst_strobe", data_strobe, 0);
    check_val("rst_data", data, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_capturing", capturing, 0);
    reset_n = 1;
    repeat (4) step();

    // constant probe: only the initial record
    sig = 4'hA;
    repeat (SYNC + 2) step();
    obs.delete();
    arm = 1;
    run_until_bytes(6, 20);
    repeat (10) step();
    check_val("hold_count", obs.size(), 6);
    check_bytes("hold_bytes", 0, 48'hA0_0000_0000_00);

    // change at ts=0x123
    arm = 0; sig = 4'h0;
    repeat (SYNC + 2) step();
    obs.delete();
    arm = 1;
    k = 0;
    while (m_ts != 44'h123 - SYNC && k < 400) begin step(); k++; end
    check_val("reach_ts", m_ts, 44'h123 - SYNC);
    sig = 4'h5;
    run_until_bytes(12, 40);
    check_bytes("chg_bytes", 6, 48'h50_0000_0001_23);

    // backpressure after byte2
    arm = 0; step();
    arm = 1;
    obs.delete();
    run_until_bytes(3, 20);
    fifo_full = 1;
    repeat (3) step();
    fifo_full = 0;
    run_until_bytes(6, 20);
    repeat (4) step();
    check_val("bp_count", obs.size(), 6);
    check_bytes("bp_bytes", 0, 48'h50_0000_0000_00);

    // three back-to-back changes: third dropped
    arm = 0; step();
    arm = 1;
    run_until_bytes(obs.size() + 6, 20);
    repeat (3) step();
    obs.delete();
    sig = 4'h1; step();
    sig = 4'h2; step();
    sig = 4'h3; step();
    run_until_bytes(12, 40);
    repeat (10) step();
    check_val("ovf_count", obs.size(), 12);
    check_val("ovf_set", overflow, 1);
    check_val("ovf_rec1", obs[0][7:4], 4'h1);
    check_val("ovf_rec2", obs[6][7:4], 4'h2);
    arm = 0; step();
    arm = 1; step();
    #1 check_val("ovf_clear", overflow, 0);
    repeat (10) step();

    // keepalive on wrap
    force dut.r_ts = 44'hFFF_FFFF_FFFE;
    m_ts = 44'hFFF_FFFF_FFFE;
    #1 release dut.r_ts;
    obs.delete();
    run_until_bytes(6, 10);
    check_bytes("keepalive", 0, 48'h30_0000_0000_00);
    repeat (4) step();

    // reset during byte3
    arm = 0; step();
    arm = 1;
    obs.delete();
    run_until_bytes(3, 20);
    #1 check_val("pre_rst_strobe", data_strobe, 1);
    reset_n = 0;
    #1;
    check_val("midrst_strobe", data_strobe, 0);
    check_val("midrst_data", data, 0);
    check_val("midrst_capturing", capturing, 0);
    arm = 0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1;
    repeat (8) step();
    check_val("post_rst_count", obs.size(), 3);
    #1 check_val("post_rst_data", data, 0);

    // random traffic
    arm = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) sig = 4'($urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      if (arm && $urandom_range(0, 299) == 0) arm = 0;
      else if (!arm && $urandom_range(0, 3) == 0) arm = 1;
      step();
    end
    fifo_full = 0; arm = 0;
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
